// File: rtl/systolic_feeder_4x4_pkg.sv
// systolic_pkg: shared sizes, feeder FSM states and the lane-skew slice helper
package systolic_pkg;
  localparam int N = 4;
  localparam int FEED_CYCLES = 2 * N - 1;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} feed_state_t;
  function automatic logic [2:0] lane_slice(input logic [2:0] t, input logic [1:0] lane);
    logic [2:0] d;
    d = t - {1'b0, lane};
    return {t >= {1'b0, lane} && d <= 3'd3, d[1:0]};
  endfunction
endpackage

// File: rtl/systolic_feeder_4x4_if.sv
// systolic_feeder_4x4_if: load port, run control and array feed lanes of the feeder
interface systolic_feeder_4x4_if import systolic_pkg::*; #(parameter int DW = 32) ();
  logic wr_en;
  logic wr_sel;
  logic [1:0] wr_row;
  logic [N*DW-1:0] wr_data;
  logic wr_ready;
  logic start;
  logic busy;
  logic done;
  logic arr_rst_n;
  logic [N*DW-1:0] a_feed;
  logic [N*DW-1:0] b_feed;
  modport slave (
    input wr_en, wr_sel, wr_row, wr_data, start,
    output wr_ready, busy, done, arr_rst_n, a_feed, b_feed
  );
  modport master (
    output wr_en, wr_sel, wr_row, wr_data, start,
    input wr_ready, busy, done, arr_rst_n, a_feed, b_feed
  );
endinterface

// File: rtl/systolic_feeder_4x4_skew_mux.sv
// systolic_skew_mux: selects the skewed, zero-padded element one lane carries at slice t
module systolic_skew_mux import systolic_pkg::*; #(
  parameter int DW = 32
) (
  input  logic [N*DW-1:0] vec_i,
  input  logic [2:0]      t_i,
  input  logic [1:0]      lane_i,
  output logic [DW-1:0]   elem_o
);
  logic [2:0] sel;
  assign sel = lane_slice(t_i, lane_i);
  assign elem_o = sel[2] ? vec_i[sel[1:0]*DW +: DW] : '0;
endmodule

// File: rtl/systolic_feeder_4x4.sv
// systolic_feeder_4x4: buffers X/Y and streams them skewed into the 4x4 systolic array
module systolic_feeder_4x4 import systolic_pkg::*; #(
  parameter int DW = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  systolic_feeder_4x4_if.slave bus
);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1) > 0 ? $clog2(DRAIN_CYCLES + 1) : 1;
  feed_state_t state_q;
  logic [2:0] cnt_q;
  logic [2:0] t_sel;
  logic [DCW-1:0] drain_q;
  logic [N*DW-1:0] x_q [N];
  logic [N*DW-1:0] y_q [N];
  logic [N*DW-1:0] y_col [N];
  logic [N*DW-1:0] a_mux;
  logic [N*DW-1:0] b_mux;
  logic [N*DW-1:0] a_q;
  logic [N*DW-1:0] b_q;
  logic busy_q;
  logic done_q;
  logic arr_rst_n_q;
  assign t_sel = state_q == S_FEED ? cnt_q + 3'd1 : 3'd0;
  for (genvar l = 0; l < N; l++) begin : g_lane
    for (genvar k = 0; k < N; k++) begin : g_col
      assign y_col[l][k*DW +: DW] = y_q[k][l*DW +: DW];
    end
    systolic_skew_mux #(.DW(DW)) u_a (
      .vec_i(y_col[l]), .t_i(t_sel), .lane_i(2'(l)), .elem_o(a_mux[l*DW +: DW])
    );
    systolic_skew_mux #(.DW(DW)) u_b (
      .vec_i(x_q[l]), .t_i(t_sel), .lane_i(2'(l)), .elem_o(b_mux[l*DW +: DW])
    );
  end
  assign bus.wr_ready = ~busy_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.arr_rst_n = arr_rst_n_q;
  assign bus.a_feed = a_q;
  assign bus.b_feed = b_q;
  // run FSM with buffer writes and registered feed/control outputs for the next cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      drain_q <= '0;
      x_q <= '{default: '0};
      y_q <= '{default: '0};
      a_q <= '0;
      b_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      arr_rst_n_q <= 1'b0;
    end else begin
      arr_rst_n_q <= 1'b1;
      done_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (bus.wr_en && bus.wr_sel) y_q[bus.wr_row] <= bus.wr_data;
          if (bus.wr_en && !bus.wr_sel) x_q[bus.wr_row] <= bus.wr_data;
          if (bus.start) begin
            state_q <= S_CLEAR;
            busy_q <= 1'b1;
            arr_rst_n_q <= 1'b0;
          end
        end
        S_CLEAR: begin
          state_q <= S_FEED;
          cnt_q <= '0;
          a_q <= a_mux;
          b_q <= b_mux;
        end
        S_FEED: begin
          cnt_q <= cnt_q + 3'd1;
          a_q <= a_mux;
          b_q <= b_mux;
          if (cnt_q == 3'(FEED_CYCLES - 1)) begin
            state_q <= DRAIN_CYCLES == 0 ? S_DONE : S_DRAIN;
            done_q <= DRAIN_CYCLES == 0;
            drain_q <= '0;
          end
        end
        S_DRAIN: begin
          drain_q <= drain_q + DCW'(1);
          if (drain_q == DCW'(DRAIN_CYCLES - 1)) begin
            state_q <= S_DONE;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_feeder_4x4.sv
// tb_systolic_feeder_4x4: directed runs with a reference systolic array and done scoreboard
module tb_systolic_feeder_4x4;
  typedef logic [3:0][3:0][31:0] mat_t;
  typedef logic [3:0][3:0][63:0] cmat_t;
  typedef struct packed {
    logic [31:0] scyc;
    logic [31:0] lat;
    cmat_t c;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t pe1;
  int pend1 = 0;
  systolic_feeder_4x4_if #(.DW(32)) b0 ();
  systolic_feeder_4x4_if #(.DW(32)) b1 ();
  systolic_feeder_4x4 #(.DW(32), .DRAIN_CYCLES(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
  systolic_feeder_4x4 #(.DW(32), .DRAIN_CYCLES(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic [3:0][31:0] af [2];
  logic [3:0][31:0] bf [2];
  logic arn [2];
  assign af[0] = b0.a_feed;
  assign bf[0] = b0.b_feed;
  assign arn[0] = b0.arr_rst_n;
  assign af[1] = b1.a_feed;
  assign bf[1] = b1.b_feed;
  assign arn[1] = b1.arr_rst_n;
  cmat_t acc [2];
  mat_t ah [2];
  mat_t bh [2];
  function automatic logic [31:0] a_in(int u, int i, int j);
    return i == 0 ? af[u][j] : ah[u][i == 0 ? 0 : i - 1][j];
  endfunction
  function automatic logic [31:0] b_in(int u, int i, int j);
    return j == 0 ? bf[u][i] : bh[u][i][j == 0 ? 0 : j - 1];
  endfunction
  // reference array: a flows down columns, b flows right along rows, PE accumulates a*b
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (!arn[u]) begin
            acc[u][i][j] <= '0;
            ah[u][i][j] <= '0;
            bh[u][i][j] <= '0;
          end else begin
            acc[u][i][j] <= acc[u][i][j] + 64'(a_in(u, i, j)) * 64'(b_in(u, i, j));
            ah[u][i][j] <= a_in(u, i, j);
            bh[u][i][j] <= b_in(u, i, j);
          end
  end
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_mat(string nm, cmat_t act, cmat_t exp);
    int bad = -1;
    checks++;
    for (int k = 0; k < 16; k++) if (bad < 0 && act[k/4][k%4] !== exp[k/4][k%4]) bad = k;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: C[%0d][%0d] got %h expected %h", nm, bad / 4, bad % 4,
               act[bad/4][bad%4], exp[bad/4][bad%4]);
    end
  endtask
  // scoreboard monitor: every done pops one expected run and checks latency and C
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pend1 > 0) begin
        pend1--;
        if (pend1 == 0) chk_mat("c_drain0", acc[1], pe1.c);
      end
      if (rst && b0.done === 1'b1) begin
        if (q0.size() == 0) chk("done0_unexpected", 128'(b0.done), 128'(0));
        else begin
          e = q0.pop_front();
          chk("latency0", 128'(cyc - e.scyc), 128'(e.lat));
          chk_mat("c0", acc[0], e.c);
        end
      end
      if (rst && b1.done === 1'b1) begin
        if (q1.size() == 0) chk("done1_unexpected", 128'(b1.done), 128'(0));
        else begin
          pe1 = q1.pop_front();
          chk("latency1", 128'(cyc - pe1.scyc), 128'(pe1.lat));
          pend1 = 3;
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(int u, logic en, logic sel, logic [1:0] row, logic [127:0] d, logic st);
    if (u == 0) begin
      b0.wr_en = en; b0.wr_sel = sel; b0.wr_row = row; b0.wr_data = d; b0.start = st;
    end else begin
      b1.wr_en = en; b1.wr_sel = sel; b1.wr_row = row; b1.wr_data = d; b1.start = st;
    end
  endtask
  task automatic load(int u, logic sel, mat_t m);
    for (int r = 0; r < 4; r++) begin
      drive(u, 1'b1, sel, 2'(r), m[r], 1'b0);
      tick();
    end
    drive(u, 1'b0, 1'b0, 2'd0, '0, 1'b0);
  endtask
  task automatic start(int u, cmat_t c, int lat);
    drive(u, 1'b0, 1'b0, 2'd0, '0, 1'b1);
    if (u == 0) q0.push_back('{scyc: 32'(cyc), lat: 32'(lat), c: c});
    else q1.push_back('{scyc: 32'(cyc), lat: 32'(lat), c: c});
    tick();
    drive(u, 1'b0, 1'b0, 2'd0, '0, 1'b0);
  endtask
  function automatic mat_t ident();
    mat_t m = '0;
    for (int i = 0; i < 4; i++) m[i][i] = 32'd1;
    return m;
  endfunction
  function automatic mat_t seqm();
    mat_t m;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m[r][c] = 32'(4 * r + c + 1);
    return m;
  endfunction
  function automatic mat_t xs();
    mat_t m;
    for (int i = 0; i < 4; i++) for (int k = 0; k < 4; k++) m[i][k] = 32'(16 * i + k);
    return m;
  endfunction
  function automatic cmat_t widen(mat_t m);
    cmat_t c;
    for (int r = 0; r < 4; r++) for (int k = 0; k < 4; k++) c[r][k] = 64'(m[r][k]);
    return c;
  endfunction
  function automatic logic [127:0] lanes(int l0, int l1, int l2, int l3);
    return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
  endfunction
  initial begin
    cmat_t ones_c;
    for (int k = 0; k < 16; k++) ones_c[k/4][k%4] = 64'hFFFF_FFF8_0000_0004;
    drive(0, 1'b0, 1'b0, 2'd0, '0, 1'b0);
    drive(1, 1'b0, 1'b0, 2'd0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_feed", b0.a_feed, 128'(0));
    chk("rst_b_feed", b0.b_feed, 128'(0));
    chk("rst_busy", 128'(b0.busy), 128'(0));
    chk("rst_done", 128'(b0.done), 128'(0));
    chk("rst_arr_rst_n", 128'(b0.arr_rst_n), 128'(0));
    rst = 1'b1;
    tick();
    chk("arr_rst_n_release", 128'(b0.arr_rst_n), 128'(1));
    chk("wr_ready_idle", 128'(b0.wr_ready), 128'(1));
    load(0, 1'b0, ident());
    load(0, 1'b1, seqm());
    start(0, widen(seqm()), 13);
    chk("t1_clear_arr_rst_n", 128'(b0.arr_rst_n), 128'(0));
    chk("t1_clear_feeds", b0.a_feed | b0.b_feed, 128'(0));
    chk("t1_busy", 128'(b0.busy), 128'(1));
    repeat (3) tick();
    chk("t1_b_t2", b0.b_feed, lanes(0, 1, 0, 0));
    tick();
    chk("t1_a_t3", b0.a_feed, lanes(13, 10, 7, 4));
    repeat (9) tick();
    load(0, 1'b0, xs());
    load(0, 1'b1, '0);
    start(0, '0, 13);
    tick();
    chk("t2_b_t0", b0.b_feed, lanes(0, 0, 0, 0));
    tick();
    chk("t2_b_t1", b0.b_feed, lanes(1, 16, 0, 0));
    repeat (2) tick();
    chk("t2_b_t3", b0.b_feed, lanes(3, 18, 33, 48));
    repeat (3) tick();
    chk("t2_b_t6", b0.b_feed, lanes(0, 0, 0, 51));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_tail_zero", b0.a_feed | b0.b_feed, 128'(0));
    end
    tick();
    start(0, '0, 13);
    for (int k = 1; k <= 13; k++) begin
      chk("t3_wr_ready_busy", 128'(b0.wr_ready), 128'(0));
      drive(0, k >= 9 && k <= 12, 1'b0, 2'd1, '1, k == 3);
      tick();
    end
    drive(0, 1'b0, 1'b0, 2'd0, '0, 1'b0);
    repeat (3) tick();
    chk("t3_no_rerun", 128'(b0.busy), 128'(0));
    load(0, 1'b1, ident());
    start(0, widen(xs()), 13);
    repeat (13) tick();
    drive(0, 1'b0, 1'b0, 2'd0, '0, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, 2'd0, '0, 1'b0);
    repeat (4) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("t4_abort_feeds", b0.a_feed | b0.b_feed, 128'(0));
    chk("t4_abort_busy", 128'(b0.busy), 128'(0));
    chk("t4_abort_arr_rst_n", 128'(b0.arr_rst_n), 128'(0));
    tick();
    tick();
    rst = 1'b1;
    tick();
    start(0, '0, 13);
    repeat (13) tick();
    load(0, 1'b0, ident());
    load(0, 1'b1, ident());
    start(0, widen(ident()), 13);
    repeat (13) tick();
    load(0, 1'b0, '1);
    load(0, 1'b1, '1);
    start(0, ones_c, 13);
    repeat (13) tick();
    start(0, ones_c, 13);
    chk("t5_clear2_arr_rst_n", 128'(b0.arr_rst_n), 128'(0));
    tick();
    chk("t5_feed_arr_rst_n", 128'(b0.arr_rst_n), 128'(1));
    repeat (12) tick();
    load(1, 1'b0, ident());
    load(1, 1'b1, seqm());
    start(1, widen(seqm()), 9);
    repeat (15) tick();
    chk("q0_drained", 128'(q0.size()), 128'(0));
    chk("q1_drained", 128'(q1.size()), 128'(0));
    chk("pend1_drained", 128'(pend1), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/systolic_feeder_4x4.md
Name: systolic_feeder_4x4

Overview:
Upstream stage of the 4x4 systolic multiplier array. It holds operand matrices X and Y (4x4, DW-bit elements), loaded row by row. On start it streams them into the array's a/b edge lanes with diagonal skew and zero padding. It clears the array accumulators before each run and pulses done once the array outputs hold C = X*Y.

Parameters:
DW, 32, element width in bits
DRAIN_CYCLES, 4, cycles waited after the last feed slice before done

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
wr_en  in  1  load strobe for one matrix row
wr_sel  in  1  0 = X buffer, 1 = Y buffer
wr_row  in  2  row index
wr_data  in  4*DW  row data; element k in bits [k*DW +: DW]
wr_ready  out  1  load accepted this cycle (high only in IDLE)
start  in  1  begin run (sampled in IDLE only)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; C valid at array outputs
arr_rst_n  out  1  active-low clear to array rst
a_feed  out  4*DW  array a lanes; lane j in bits [j*DW +: DW]
b_feed  out  4*DW  array b lanes; lane i in bits [i*DW +: DW]

Behaviour:
- Reset (rst=0, async): state IDLE; X and Y buffers all 0; a_feed=0, b_feed=0; busy=0; done=0; arr_rst_n=0. Once rst deasserts, arr_rst_n is 1 from the first clock edge.
- Lane mapping, following array dataflow:
  - b lane i enters row i and carries X[i][k].
  - a lane j enters column j and carries Y[k][j].
  - Result: PE(i,j) accumulates X[i][k]*Y[k][j].
- Load: in IDLE, wr_ready=1. wr_en writes wr_data into the selected buffer row at the clock edge. Outside IDLE, wr_ready=0 and wr_en is ignored; buffers are unchanged.
- Load and start in the same IDLE cycle: the write lands first; the run uses the updated buffer.
- FSM: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
  - IDLE: start=1 -> CLEAR. Start outside IDLE is ignored (not queued).
  - CLEAR: exactly 1 cycle; arr_rst_n=0; feeds 0.
  - FEED: 7 cycles, t=0..6, from a 3-bit counter.
    - b lane i = X[i][t-i] when 0 <= t-i <= 3, else 0.
    - a lane j = Y[t-j][j] when 0 <= t-j <= 3, else 0.
  - DRAIN: DRAIN_CYCLES cycles; feeds 0. If DRAIN_CYCLES=0, go straight to DONE.
  - DONE: 1 cycle; done=1; feeds 0; then IDLE.
- All outputs are registered. The feed values for slice t are visible during the cycle the FSM is in FEED with counter t. busy is high from the cycle after start through the DONE cycle.
- Total run: 1 + 7 + DRAIN_CYCLES + 1 cycles from start acceptance to the return to IDLE.
- No arithmetic in this block. Element values pass through bit-exact; overflow is the array's concern.
- Reset mid-run: immediate return to reset state, including cleared buffers. No done pulse for the aborted run.
- Back-to-back: start asserted in the cycle after DONE (IDLE) is accepted; buffers are retained, so the same matrices can be rerun.

Decomposition:
- Shared package systolic_pkg:
  - N=4
  - FEED_CYCLES=2*N-1
  - feeder state enum (IDLE, CLEAR, FEED, DRAIN, DONE)
  - lane slice helper function
- Natural sub-module: systolic_skew_mux. It is combinational and selects the padded, skewed element for one lane from a buffer row/column given t and the lane index. Instantiate 8 times (4 a lanes, 4 b lanes).

Test Plan:
1. X = identity, Y[r][c] = 4r+c+1 -> after done, array C[i][j] = Y[i][j]. done pulses exactly once, 1+7+4+1 = 13 cycles after start acceptance.
2. Skew check, X[i][k] = 16i+k, Y = 0:
   - t=0: b_feed lanes = {X00, 0, 0, 0}.
   - t=3: lanes = {X03, X12, X21, X30}.
   - t=6: lanes = {0, 0, 0, X33}.
   - All zeros in CLEAR, DRAIN and DONE.
3. start pulsed during FEED, and wr_en with wr_data=all 1s during DRAIN -> no second run; buffer contents unchanged; wr_ready=0 throughout busy.
4. rst=0 at FEED t=3 -> outputs zero and busy=0 immediately, arr_rst_n=0, no done. After release, loading X=Y=identity and starting gives C = identity.
5. Back-to-back run with DW=32, X = Y = all 0xFFFFFFFF:
   - First run C result is checked.
   - Second start in the cycle after DONE gives arr_rst_n=0 for one cycle, then an identical C; no accumulation across runs.
6. DRAIN_CYCLES=0 build -> done asserts 9 cycles after start acceptance, and C is still correct.
